// File: rtl/wadd_pkg.sv
// Shared types and sizing helpers for the multi-precision adder sequencer.
// Holds the FSM encoding, the default geometry and the chunk and index width helpers.
package wadd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int chunk_w(input int adder_size);
    return adder_size - 1;
  endfunction

  function automatic int idx_w(input int num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

  localparam int DEF_ADDER_SIZE = 32;
  localparam int DEF_GROUP_SIZE = 5;
  localparam int DEF_NUM_CHUNKS = 4;
  localparam int CW             = chunk_w(DEF_ADDER_SIZE);
  localparam int WW             = CW * DEF_NUM_CHUNKS;

endpackage

// File: rtl/wide_add_sequencer_slansky.sv
// Sparse Sklansky adder on [ADDER_SIZE-1:1]: ripple inside GROUP_SIZE-bit groups, prefix tree across groups.
// Purely combinational (0 cycles); no flow control; cin enters as prefix position 0.
module SLANSKY #(
  parameter int ADDER_SIZE = 32,
  parameter int GROUP_SIZE = 5
) (
  input  logic [ADDER_SIZE-1:1] A,
  input  logic [ADDER_SIZE-1:1] B,
  input  logic                  cin,
  output logic [ADDER_SIZE-1:1] sum,
  output logic                  cout
);

  localparam int N  = ADDER_SIZE - 1;
  localparam int NG = (N + GROUP_SIZE) / GROUP_SIZE;
  localparam int LV = $clog2(NG);

  logic [N:0]    g, p, c;
  logic [NG-1:0] gg, gp;

  always_comb begin
    int pos;
    int j;
    pos = 0;
    j   = 0;
    g   = {A & B, cin};
    p   = {A ^ B, 1'b0};
    gg  = '0;
    gp  = '0;
    c   = '0;
    for (int k = 0; k < NG; k++) begin
      gp[k] = 1'b1;
      for (int b = 0; b < GROUP_SIZE; b++) begin
        pos = (k * GROUP_SIZE + b <= N) ? (k * GROUP_SIZE + b) : N;
        if (k * GROUP_SIZE + b <= N) begin
          gg[k] = g[pos] | (p[pos] & gg[k]);
          gp[k] = gp[k] & p[pos];
        end
      end
    end
    // In-place update is safe: the partner node has bit l clear, so it is untouched at level l.
    for (int l = 0; l < LV; l++) begin
      for (int k = 0; k < NG; k++) begin
        if (((k >> l) & 1) == 1) begin
          j     = ((k >> l) << l) - 1;
          gg[k] = gg[k] | (gp[k] & gg[j]);
          gp[k] = gp[k] & gp[j];
        end
      end
    end
    for (int i = 0; i <= N; i++) begin
      if (i % GROUP_SIZE == 0) begin
        j    = (i / GROUP_SIZE) - 1;
        c[i] = (j < 0) ? 1'b0 : gg[(j < 0) ? 0 : j];
      end else begin
        c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
    end
    sum  = p[N:1] ^ c[N:1];
    cout = gg[NG-1];
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide add over one reused SLANSKY, one chunk per clock; result valid 5 edges after accept (accept edge included).
// No overlap: in_ready low in RUN/DONE, DONE holds the result until out_ready. WADD_SUB_EN adds in_sub (A-B).
module wide_add_sequencer
  import wadd_pkg::*;
#(
  parameter int  ADDER_SIZE = DEF_ADDER_SIZE,
  parameter int  GROUP_SIZE = DEF_GROUP_SIZE,
  parameter int  NUM_CHUNKS = DEF_NUM_CHUNKS,
  localparam int CHUNK_W    = chunk_w(ADDER_SIZE),
  localparam int WIDE_W     = CHUNK_W * NUM_CHUNKS,
  localparam int IDX_W      = idx_w(NUM_CHUNKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDE_W-1:0] in_a,
  input  logic [WIDE_W-1:0] in_b,
  input  logic              in_cin,
`ifdef WADD_SUB_EN
  input  logic              in_sub,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDE_W-1:0] out_sum,
  output logic              out_cout
);

  state_t              state_q, state_d;
  logic [WIDE_W-1:0]   opa_q, opa_d, opb_q, opb_d, sum_q, sum_d;
  logic                carry_q, carry_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CHUNK_W-1:0]  chunk_a, chunk_b, chunk_sum;
  logic                chunk_cout;
`ifdef WADD_SUB_EN
  logic                sub_q, sub_d;
`endif

  always_comb begin
    chunk_a = opa_q[idx_q*CHUNK_W +: CHUNK_W];
`ifdef WADD_SUB_EN
    chunk_b = opb_q[idx_q*CHUNK_W +: CHUNK_W] ^ {CHUNK_W{sub_q}};
`else
    chunk_b = opb_q[idx_q*CHUNK_W +: CHUNK_W];
`endif
  end

  SLANSKY #(
    .ADDER_SIZE(ADDER_SIZE),
    .GROUP_SIZE(GROUP_SIZE)
  ) u_adder (
    .A   (chunk_a),
    .B   (chunk_b),
    .cin (carry_q),
    .sum (chunk_sum),
    .cout(chunk_cout)
  );

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
`ifdef WADD_SUB_EN
    sub_d     = sub_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          opa_d   = in_a;
          opb_d   = in_b;
          idx_d   = '0;
          state_d = RUN;
`ifdef WADD_SUB_EN
          // Subtraction is A + ~B + 1, so the incoming carry is overridden.
          sub_d   = in_sub;
          carry_d = in_sub | in_cin;
`else
          carry_d = in_cin;
`endif
        end
      end
      RUN: begin
        sum_d[idx_q*CHUNK_W +: CHUNK_W] = chunk_sum;
        carry_d = chunk_cout;
        // Index parks on the last chunk; it is only ever reloaded from IDLE.
        if (idx_q == IDX_W'(NUM_CHUNKS - 1)) state_d = DONE;
        else                                 idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
`ifdef WADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
`ifdef WADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = carry_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: directed corner cases plus randomized operands against a wide-arithmetic model.
module tb_wide_add_sequencer;

  localparam int WW = wadd_pkg::WW;
  localparam int NC = wadd_pkg::DEF_NUM_CHUNKS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WW-1:0] in_a = '0;
  logic [WW-1:0] in_b = '0;
  logic          in_cin = 1'b0;
`ifdef WADD_SUB_EN
  logic          in_sub = 1'b0;
`endif
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WW-1:0] out_sum;
  logic          out_cout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wide_add_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
`ifdef WADD_SUB_EN
    .in_sub   (in_sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout)
  );

  // Reference: plain unsigned wide arithmetic, carry/no-borrow in the top bit.
  function automatic logic [WW:0] ref_result(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                             input logic cin, input logic sub);
    logic [WW:0] r;
    if (sub) begin
      r[WW-1:0] = a - b;
      r[WW]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{WW{1'b0}}, cin};
    end
    return r;
  endfunction

  task tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_wide(output logic [WW-1:0] v);
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    v = t[WW-1:0];
  endtask

  task automatic rand_op(output logic [WW-1:0] a, output logic [WW-1:0] b, output logic cin);
    int mode;
    mode = $urandom_range(0, 3);
    rand_wide(a);
    rand_wide(b);
    cin = 1'($urandom_range(0, 1));
    if (mode == 1) begin a = '1; b = '0; end
    if (mode == 2) b = ~a;
  endtask

  task automatic start_op(input logic [WW-1:0] a, input logic [WW-1:0] b, input logic cin,
                          input logic sub, output bit ok);
    int n;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
`ifdef WADD_SUB_EN
    in_sub = sub;
`endif
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    ok = in_ready;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int edges, output bit ok);
    edges = 0;
    while (!out_valid && edges < 20) begin tick(); edges++; end
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_tests++; if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum got=%h want=0", out_sum); end
    n_tests++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_out_cout got=%b want=0", out_cout); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [WW-1:0] ta[3], tbv[3], te[3];
    logic          tc[3], tco[3];
    int            edges;
    bit            ok1, ok2;
    ta[0] = 124'h1E0;     tbv[0] = 124'hF; tc[0] = 1'b0; te[0] = 124'h1EF;      tco[0] = 1'b0;
    ta[1] = '1;           tbv[1] = '0;     tc[1] = 1'b1; te[1] = '0;            tco[1] = 1'b1;
    ta[2] = 124'h7FFFFFFF; tbv[2] = 124'h1; tc[2] = 1'b0; te[2] = 124'h80000000; tco[2] = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tbv[i], tc[i], 1'b0, ok1);
      wait_out(edges, ok2);
      n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL directed%0d_handshake accept=%0b valid=%0b want=1,1", i, ok1, ok2); end
      n_tests++; if (edges + 1 !== NC + 1) begin n_fail++; $display("FAIL directed%0d_latency got=%0d edges want=%0d", i, edges + 1, NC + 1); end
      n_tests++; if (out_sum !== te[i]) begin n_fail++; $display("FAIL directed%0d_sum got=%h want=%h", i, out_sum, te[i]); end
      n_tests++; if (out_cout !== tco[i]) begin n_fail++; $display("FAIL directed%0d_cout got=%b want=%b", i, out_cout, tco[i]); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [WW-1:0] a, b, g;
    logic          cin;
    logic [WW:0]   exp;
    int            edges;
    bit            ok1, ok2;
    for (int i = 0; i < 24; i++) begin
      rand_op(a, b, cin);
      exp = ref_result(a, b, cin, 1'b0);
      out_ready = 1'b0;
      start_op(a, b, cin, 1'b0, ok1);
      rand_wide(g); in_a = g;
      rand_wide(g); in_b = g;
      in_cin = ~cin;
      wait_out(edges, ok2);
      repeat ($urandom_range(0, 2)) tick();
      n_tests++;
      if (!(ok1 && ok2) || {out_cout, out_sum} !== exp) begin
        n_fail++;
        $display("FAIL random%0d got=%h want=%h valid=%0b", i, {out_cout, out_sum}, exp, ok2);
      end
      out_ready = 1'b1;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] a, b, g;
    logic          cin;
    logic [WW:0]   exp;
    int            acc_prev, acc_now, n, edges;
    bit            ok;
    acc_prev = 0;
    out_ready = 1'b1;
`ifdef WADD_SUB_EN
    in_sub = 1'b0;
`endif
    rand_op(a, b, cin);
    for (int i = 0; i < 5; i++) begin
      in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin tick(); n++; end
      exp = ref_result(a, b, cin, 1'b0);
      tick();
      acc_now = cyc;
      rand_wide(g); in_a = g;
      rand_wide(g); in_b = g;
      in_cin = ~cin;
      rand_op(a, b, cin);
      wait_out(edges, ok);
      n_tests++;
      if (!ok || {out_cout, out_sum} !== exp) begin
        n_fail++;
        $display("FAIL b2b%0d_result got=%h want=%h valid=%0b", i, {out_cout, out_sum}, exp, ok);
      end
      if (i > 0) begin
        n_tests++;
        if (acc_now - acc_prev != NC + 2) begin
          n_fail++;
          $display("FAIL b2b%0d_spacing got=%0d cycles want=%0d", i, acc_now - acc_prev, NC + 2);
        end
      end
      acc_prev = acc_now;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [WW-1:0] a, b, g;
    logic          cin;
    logic [WW:0]   exp;
    int            edges, bad;
    bit            ok1, ok2;
    rand_op(a, b, cin);
    exp = ref_result(a, b, cin, 1'b0);
    out_ready = 1'b0;
    start_op(a, b, cin, 1'b0, ok1);
    wait_out(edges, ok2);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      rand_wide(g); in_a = g;
      in_valid = ~in_valid;
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_cout, out_sum} !== exp) bad++;
    end
    n_tests++;
    if (!(ok1 && ok2) || bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold bad_cycles=%0d want=0 got=%h want=%h", bad, {out_cout, out_sum}, exp);
    end
    rand_op(a, b, cin);
    exp = ref_result(a, b, cin, 1'b0);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release in_ready=%b out_valid=%b want=1,0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    wait_out(edges, ok2);
    n_tests++;
    if (!ok2 || edges != NC || {out_cout, out_sum} !== exp) begin
      n_fail++;
      $display("FAIL backpressure_next got=%h want=%h edges=%0d want=%0d", {out_cout, out_sum}, exp, edges, NC);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    logic [WW-1:0] a, b;
    logic          cin;
    logic [WW:0]   exp;
    int            edges, seen;
    bit            ok1, ok2;
    out_ready = 1'b1;
    rand_op(a, b, cin);
    start_op(a, b, cin, 1'b0, ok1);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0) begin
      n_fail++;
      $display("FAIL midreset_state in_ready=%b out_valid=%b sum=%h want=1,0,0", in_ready, out_valid, out_sum);
    end
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin tick(); if (out_valid !== 1'b0) seen++; end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL midreset_no_output valid_cycles=%0d want=0", seen); end
    rand_op(a, b, cin);
    exp = ref_result(a, b, cin, 1'b0);
    start_op(a, b, cin, 1'b0, ok1);
    wait_out(edges, ok2);
    n_tests++;
    if (!(ok1 && ok2) || {out_cout, out_sum} !== exp) begin
      n_fail++;
      $display("FAIL midreset_after got=%h want=%h", {out_cout, out_sum}, exp);
    end
    tick();
  endtask

`ifdef WADD_SUB_EN
  task automatic test_sub();
    logic [WW-1:0] a, b, e;
    logic          cin;
    logic [WW:0]   exp;
    int            edges;
    bit            ok1, ok2;
    out_ready = 1'b1;
    e = '1;
    e = e - 1'b1;
    start_op(124'd5, 124'd7, 1'b0, 1'b1, ok1);
    wait_out(edges, ok2);
    n_tests++;
    if (!(ok1 && ok2) || out_sum !== e || out_cout !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_5_minus_7 got=%b_%h want=0_%h", out_cout, out_sum, e);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      rand_op(a, b, cin);
      if (i == 0) b = a;
      exp = ref_result(a, b, cin, 1'b1);
      start_op(a, b, cin, 1'b1, ok1);
      wait_out(edges, ok2);
      n_tests++;
      if (!(ok1 && ok2) || {out_cout, out_sum} !== exp) begin
        n_fail++;
        $display("FAIL sub_random%0d got=%h want=%h", i, {out_cout, out_sum}, exp);
      end
      tick();
    end
    in_sub = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
`ifdef WADD_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
